// File: rtl/blit_write_combiner.sv
// blit_write_combiner
//   Last stage of the blitter pipeline. Per-pixel byte writes from the colour
//   stage are merged into 32-bit word writes with byte strobes. Merged words
//   queue in a small FIFO and go out on a valid/ready memory write port.
//
// Ports
//   clock, reset           : clock, synchronous active-high reset
//   p4_write/address/wdata : byte write stream (no backpressure)
//   flush_req              : evict the partial word (end of blit)
//   blit_stall             : FIFO near full, upstream must stop issuing pixels
//   blit_busy              : combine register or FIFO still holds data
//   overflow               : sticky, an eviction was dropped because the FIFO was full
//   mem_valid/ready        : write request handshake
//   mem_address/wdata/wstrb: word address (bits [1:0] = 0), data, byte enables
//
// Optional feature (define BLIT_WRITE_STATS_EN):
//   stat_clear in, stat_words / stat_bytes out -- wrapping counters of
//   accepted words and written bytes; stat_clear wins over an increment.

module blit_write_combiner #(
    parameter int FIFO_DEPTH   = 8,
    parameter int STALL_MARGIN = 4,
    parameter int IDLE_FLUSH   = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        p4_write,
    input  logic [25:0] p4_address,
    input  logic [7:0]  p4_wdata,
    input  logic        flush_req,
    output logic        blit_stall,
    output logic        blit_busy,
    output logic        overflow,
    output logic        mem_valid,
    output logic [25:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready
`ifdef BLIT_WRITE_STATS_EN
    ,
    input  logic        stat_clear,
    output logic [31:0] stat_words,
    output logic [31:0] stat_bytes
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = (IDLE_FLUSH > 0) ? $clog2(IDLE_FLUSH + 1) : 1;

    typedef struct packed {
        logic [23:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } entry_t;

    // ---------------- combine register ----------------
    logic          cb_valid_q, cb_valid_d;
    logic [23:0]   cb_addr_q,  cb_addr_d;
    logic [31:0]   cb_data_q,  cb_data_d;
    logic [3:0]    cb_strb_q,  cb_strb_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;

    logic          idle_hit, evict;
    logic [4:0]    lane_shift;
    logic [31:0]   lane_data, lane_mask;
    logic [3:0]    lane_strb;

    assign lane_shift = {p4_address[1:0], 3'b000};
    assign lane_data  = 32'(p4_wdata) << lane_shift;
    assign lane_mask  = 32'h0000_00FF << lane_shift;
    assign lane_strb  = 4'b0001 << p4_address[1:0];

    // IDLE_FLUSH == 0 disables the timeout; the counter then sits at 0.
    assign idle_hit = (IDLE_FLUSH != 0) && (idle_cnt_q == IW'(IDLE_FLUSH));

    assign evict = cb_valid_q &&
                   ((cb_strb_q == 4'hF) ||
                    (p4_write && (p4_address[25:2] != cb_addr_q)) ||
                    flush_req || idle_hit);

    always_comb begin
        cb_valid_d = cb_valid_q;
        cb_addr_d  = cb_addr_q;
        cb_data_d  = cb_data_q;
        cb_strb_d  = cb_strb_q;
        if (evict || !cb_valid_q) begin
            // Start a fresh word (or empty the register if nothing arrives).
            cb_valid_d = p4_write;
            if (p4_write) begin
                cb_addr_d = p4_address[25:2];
                cb_data_d = lane_data;
                cb_strb_d = lane_strb;
            end
        end else if (p4_write) begin
            // Same word: merge the lane; a repeated lane simply overwrites.
            cb_data_d = (cb_data_q & ~lane_mask) | lane_data;
            cb_strb_d = cb_strb_q | lane_strb;
        end
    end

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (p4_write || !cb_valid_d)
            idle_cnt_d = '0;
        else if (idle_cnt_q != IW'(IDLE_FLUSH))
            idle_cnt_d = idle_cnt_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cb_valid_q <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            cb_valid_q <= cb_valid_d;
            idle_cnt_q <= idle_cnt_d;
        end
        cb_addr_q <= cb_addr_d;
        cb_data_q <= cb_data_d;
        cb_strb_q <= cb_strb_d;
    end

    // ---------------- word FIFO ----------------
    entry_t        fifo_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          blit_stall_q, overflow_q;
    logic          full, pop, push_ok;
    entry_t        head;

    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign pop     = (count_q != '0) && mem_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok = evict && (!full || pop);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop)
            count_d = count_q + 1'b1;
        else if (!push_ok && pop)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            blit_stall_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q      <= count_d;
            // Registered from the next count so it tracks count with no lag.
            blit_stall_q <= (count_d >= (AW+1)'(FIFO_DEPTH - STALL_MARGIN));
            if (evict && !push_ok) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) fifo_q[wr_ptr_q] <= '{addr: cb_addr_q, data: cb_data_q, strb: cb_strb_q};
    end

    assign head        = fifo_q[rd_ptr_q];
    assign mem_valid   = (count_q != '0);
    assign mem_address = {head.addr, 2'b00};
    assign mem_wdata   = head.data;
    assign mem_wstrb   = head.strb;
    assign blit_stall  = blit_stall_q;
    assign overflow    = overflow_q;
    assign blit_busy   = cb_valid_q || (count_q != '0);

`ifdef BLIT_WRITE_STATS_EN
    logic [31:0] stat_words_q, stat_bytes_q;
    logic [31:0] strb_pop;

    assign strb_pop = 32'(mem_wstrb[0]) + 32'(mem_wstrb[1]) +
                      32'(mem_wstrb[2]) + 32'(mem_wstrb[3]);

    always_ff @(posedge clock) begin
        if (reset || stat_clear) begin
            stat_words_q <= '0;
            stat_bytes_q <= '0;
        end else if (pop) begin
            stat_words_q <= stat_words_q + 32'd1;
            stat_bytes_q <= stat_bytes_q + strb_pop;
        end
    end

    assign stat_words = stat_words_q;
    assign stat_bytes = stat_bytes_q;
`endif

endmodule
